// File: rtl/mbox_mem_seq.sv
// MBOX memory sequencer: accepts one read, write or read-pause-write request at a time
// and runs the memory handshake with programmable wait states and odd parity.
module mbox_mem_seq #(
    parameter int MEM_WORDS   = 65536,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        req,
    input  logic        read,
    input  logic        write,
    input  logic [21:0] adr,
    input  logic [35:0] wrData,
    output logic        busy,
    output logic        ack,
    output logic [35:0] rdData,
    output logic        nxmErr,
    output logic        parErr,
    input  logic        errClr,
    output logic        memEn,
    output logic        memWe,
    output logic [21:0] memAdr,
    output logic [36:0] memWrData,
    input  logic [36:0] memRdData
);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_doWrite;
    logic        r_busy;
    logic        r_ack;
    logic [35:0] r_rdData;
    logic        r_nxmErr;
    logic        r_parErr;
    logic        r_memEn;
    logic        r_memWe;
    logic [21:0] r_memAdr;
    logic [36:0] r_memWrData;

    logic w_accept;
    logic w_nxm;
    logic w_rdParOk;

    assign w_accept  = req & (read | write);
    assign w_nxm     = {10'd0, adr} >= 32'(MEM_WORDS);
    assign w_rdParOk = ^memRdData;

    // errClr is applied first so that any error set later in this block overrides it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_doWrite   <= 1'b0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_rdData    <= 36'd0;
            r_nxmErr    <= 1'b0;
            r_parErr    <= 1'b0;
            r_memEn     <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAdr    <= 22'd0;
            r_memWrData <= 37'd0;
        end else begin
            r_ack <= 1'b0;
            if (errClr) begin
                r_nxmErr <= 1'b0;
                r_parErr <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy    <= 1'b1;
                        r_doWrite <= write;
                        r_rdData  <= 36'd0;
                        if (write) begin
                            r_memWrData <= {~(^wrData), wrData};
                        end
                        if (w_nxm) begin
                            r_state  <= ACK;
                            r_ack    <= 1'b1;
                            r_nxmErr <= 1'b1;
                        end else begin
                            r_state  <= read ? RD : WR;
                            r_cnt    <= WAIT_LD;
                            r_memEn  <= 1'b1;
                            r_memWe  <= ~read;
                            r_memAdr <= adr;
                        end
                    end
                end
                RD: begin
                    if (r_cnt == 4'd0) begin
                        r_rdData <= memRdData[35:0];
                        if (!w_rdParOk) begin
                            r_parErr <= 1'b1;
                        end
                        if (r_doWrite) begin
                            r_state <= WR;
                            r_cnt   <= WAIT_LD;
                            r_memWe <= 1'b1;
                        end else begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                            r_memEn <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WR: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_memEn <= 1'b0;
                        r_memWe <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign rdData    = r_rdData;
    assign nxmErr    = r_nxmErr;
    assign parErr    = r_parErr;
    assign memEn     = r_memEn;
    assign memWe     = r_memWe;
    assign memAdr    = r_memAdr;
    assign memWrData = r_memWrData;

endmodule

// File: doc/mbox_mem_seq.md
MBOX_MEM_SEQ -- requirements
Module: mbox_mem_seq

Interface
REQ-001 Parameter MEM_WORDS, default 65536, installed memory size in words; addresses at or above it are nonexistent.
REQ-002 Parameter WAIT_CYCLES, default 2, extra memory-access cycles per read or write phase (legal range 0..15).
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 resetN  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  MBOX request strobe, sampled only in IDLE.
REQ-006 read  in  1  request includes a read phase.
REQ-007 write  in  1  request includes a write phase; read and write together mean read-pause-write (RPW).
REQ-008 adr  in  22  physical word address [14:35].
REQ-009 wrData  in  36  write data [0:35], captured with the request.
REQ-010 busy  out  1  high from the cycle after acceptance through the ACK cycle.
REQ-011 ack  out  1  one-cycle completion pulse.
REQ-012 rdData  out  36  read result, valid while ack is high and held until the next acceptance.
REQ-013 nxmErr  out  1  sticky nonexistent-memory flag.
REQ-014 parErr  out  1  sticky read-parity flag.
REQ-015 errClr  in  1  clears nxmErr and parErr.
REQ-016 memEn  out  1  memory array enable.
REQ-017 memWe  out  1  memory write enable, qualified by memEn.
REQ-018 memAdr  out  22  memory address.
REQ-019 memWrData  out  37  write data [0:35] plus odd-parity bit [36].
REQ-020 memRdData  in  37  memory read data [0:35] plus parity bit [36], valid on the last cycle of a read phase.

Function
REQ-021 FSM states: IDLE, RD, WR, ACK.
REQ-022 In IDLE, req=1 with read or write set is accepted: adr, wrData and op latch; the next state is RD if read=1, WR if only write=1, or ACK (NXM) if adr >= MEM_WORDS.
REQ-023 In IDLE, req=1 with read=write=0 is ignored; no flag changes.
REQ-024 req is ignored while busy=1; no queuing.
REQ-025 RD and WR each last exactly WAIT_CYCLES+1 cycles, tracked by a 4-bit down-counter loaded on entry; memEn=1 throughout; memAdr = latched address.
REQ-026 memWe is 1 only in WR.
REQ-027 The last RD cycle captures memRdData[0:35] into rdData; RD exits to WR for RPW, otherwise to ACK.
REQ-028 Odd parity: if the XOR of all 37 memRdData bits is 0, parErr sets and the data is still returned.
REQ-029 memWrData[36] = NOT XOR(wrData latched); in RPW, the write phase writes the latched wrData.
REQ-030 ACK lasts one cycle (ack=1), then returns to IDLE; a new req can be accepted in the IDLE cycle after ACK.
REQ-031 Latency from req to ack: read-only or write-only = WAIT_CYCLES+2 cycles; RPW = 2*WAIT_CYCLES+3 cycles; NXM = 1 cycle.
REQ-032 NXM: no memEn, rdData=0, nxmErr set on entry to ACK.
REQ-033 When errClr and a new error set occur in the same cycle, the set wins.
REQ-034 Outside RD/WR, memEn=0, memWe=0 and memAdr holds its last value.

Reset
REQ-035 resetN=0 asynchronously forces: IDLE, counter=0, busy=0, ack=0, memEn=0, memWe=0, memAdr=0, memWrData=0, rdData=0, nxmErr=0, parErr=0.
REQ-036 Reset during RD or WR aborts the access immediately with no ack; after release the FSM is in IDLE.

Verification (MEM_WORDS=1024, WAIT_CYCLES=2)
REQ-037 Read adr=5, memory word 0o123 with correct parity -> memEn high for 3 cycles, ack at cycle 4, rdData=0o123, parErr=0.
REQ-038 Write adr=7, wrData=0o777 -> memWe high for 3 cycles, memWrData[36]=0 (9 ones, already odd), ack at cycle 4.
REQ-039 RPW adr=3, old value 0o1, wrData=0o2 -> 3 RD cycles then 3 WR cycles, a single ack at cycle 7 with rdData=0o1, memory now holds 0o2.
REQ-040 Read adr=1024 -> no memEn, ack at cycle 1, rdData=0, nxmErr=1; an errClr pulse clears it; errClr coincident with a second NXM leaves nxmErr=1.
REQ-041 Read with flipped parity bit -> parErr=1, data still returned; a second req during busy produces no second ack.
REQ-042 resetN low in the 2nd RD cycle -> memEn=0 immediately, no ack; a subsequent read completes normally.
